// File: rtl/sig_cond_pkg.sv
// Shared constants for the signal conditioner: prescaler encodings, decade
// divisors and counter widths.
package sig_cond_pkg;

    localparam int PRESC_W = 10;
    localparam int FILT_W  = 3;
    localparam int TMO_W   = 24;

    typedef enum logic [1:0] {
        PRESC_1    = 2'b00,
        PRESC_10   = 2'b01,
        PRESC_100  = 2'b10,
        PRESC_1000 = 2'b11
    } presc_sel_e;

    localparam logic [PRESC_W-1:0] DIV_1    = 10'd1;
    localparam logic [PRESC_W-1:0] DIV_10   = 10'd10;
    localparam logic [PRESC_W-1:0] DIV_100  = 10'd100;
    localparam logic [PRESC_W-1:0] DIV_1000 = 10'd1000;

    // Terminal count (D-1) of the prescaler for a given selection.
    function automatic logic [PRESC_W-1:0] presc_max(input presc_sel_e sel);
        case (sel)
            PRESC_1:   return DIV_1 - 10'd1;
            PRESC_10:  return DIV_10 - 10'd1;
            PRESC_100: return DIV_100 - 10'd1;
            default:   return DIV_1000 - 10'd1;
        endcase
    endfunction

endpackage

// File: rtl/glitch_filter.sv
// Synchroniser chain followed by a consecutive-sample glitch filter; the
// output level flips only after filt_len+1 disagreeing samples in a row.
module glitch_filter
    import sig_cond_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              sig_in,
    input  logic [FILT_W-1:0] filt_len,
    output logic              sig_clean
);

    logic [SYNC_STAGES-1:0] sync_pipe;
    logic [FILT_W-1:0]      cnt;
    logic                   sync_q;

    assign sync_q = sync_pipe[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sync_pipe <= '0;
        else        sync_pipe <= {sync_pipe[SYNC_STAGES-2:0], sig_in};
    end

    // filt_len is compared live, so a change mid-run takes effect on the next sample
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt       <= '0;
            sig_clean <= 1'b0;
        end else if (sync_q == sig_clean) begin
            cnt <= '0;
        end else if (cnt == filt_len) begin
            cnt       <= '0;
            sig_clean <= ~sig_clean;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/sig_conditioner.sv
// Conditions a raw asynchronous input: filtered level, decade-prescaled
// rising-edge pulse for a BCD counter, and a loss-of-signal timeout flag.
module sig_conditioner
    import sig_cond_pkg::*;
#(
    parameter int               SYNC_STAGES    = 2,
    parameter logic [TMO_W-1:0] TIMEOUT_CYCLES = 24'd10_000_000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        sig_in,
    input  logic [2:0]  filt_len,
    input  logic [1:0]  presc_sel,
    output logic        edge_pulse,
    output logic        sig_clean,
    output logic        no_signal
);

    logic               sig_clean_d;
    logic               rise;
    logic               sel_chg;
    presc_sel_e         sel_q;
    logic [PRESC_W-1:0] presc_cnt;
    logic [TMO_W-1:0]   tmo_cnt;
    logic [TMO_W-1:0]   tmo_nxt;

    glitch_filter #(.SYNC_STAGES(SYNC_STAGES)) u_filt (
        .clk       (clk),
        .rst_n     (rst_n),
        .sig_in    (sig_in),
        .filt_len  (filt_len),
        .sig_clean (sig_clean)
    );

    assign rise    = sig_clean & ~sig_clean_d;
    assign sel_chg = (sel_q != presc_sel_e'(presc_sel));
    assign tmo_nxt = rise                      ? '0      :
                     (tmo_cnt == TIMEOUT_CYCLES) ? tmo_cnt : tmo_cnt + 1'b1;

    // A divisor change restarts the prescaler and swallows any rise in that cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sig_clean_d <= 1'b0;
            sel_q       <= PRESC_1;
            presc_cnt   <= '0;
            edge_pulse  <= 1'b0;
        end else begin
            sig_clean_d <= sig_clean;
            sel_q       <= presc_sel_e'(presc_sel);
            edge_pulse  <= 1'b0;
            if (sel_chg) begin
                presc_cnt <= '0;
            end else if (rise) begin
                if (presc_cnt == presc_max(sel_q)) begin
                    presc_cnt  <= '0;
                    edge_pulse <= 1'b1;
                end else begin
                    presc_cnt <= presc_cnt + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_cnt   <= TIMEOUT_CYCLES;
            no_signal <= 1'b1;
        end else begin
            tmo_cnt   <= tmo_nxt;
            no_signal <= (tmo_nxt == TIMEOUT_CYCLES);
        end
    end

endmodule
